// File: rtl/test_cond_router.sv
// Conditional three-way router: beats are buffered with a route fixed at acceptance and replayed in order.
// Latency: one cycle minimum from acceptance to output. Backpressure: per-channel ready holds the head; ready_in drops when full or halted.
// Bad beats are dropped silently at the head and counted in a saturating err_count.
module test_cond_router #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode,
    input  logic [3:0] config_bits,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    input  logic       error_in,
    output logic       ready_in,
    output logic [7:0] data_out_a,
    output logic [7:0] data_out_b,
    output logic [7:0] data_out_c,
    output logic       valid_out_a,
    output logic       valid_out_b,
    output logic       valid_out_c,
    input  logic       ready_a,
    input  logic       ready_b,
    input  logic       ready_c,
    output logic [3:0] err_count,
    output logic       busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [1:0] RT_A = 2'd0;
    localparam logic [1:0] RT_B = 2'd1;
    localparam logic [1:0] RT_C = 2'd2;
    localparam logic [1:0] MODE_HALT = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        HALT   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [3:0]      err_count_q, err_count_d;
    logic [7:0]      mem_data_q  [DEPTH];
    logic [7:0]      mem_data_d  [DEPTH];
    logic [1:0]      mem_route_q [DEPTH];
    logic [1:0]      mem_route_d [DEPTH];
    logic            mem_err_q   [DEPTH];
    logic            mem_err_d   [DEPTH];

    logic            empty;
    logic            full;
    logic            push;
    logic            pop;
    logic            head_err;
    logic            head_vld;
    logic [7:0]      head_data;
    logic [1:0]      head_route;
    logic [1:0]      route_sel;

    assign empty      = (count_q == '0);
    assign full       = (count_q == FULL_CNT);
    assign head_data  = mem_data_q[rd_ptr_q];
    assign head_route = mem_route_q[rd_ptr_q];
    assign head_err   = mem_err_q[rd_ptr_q];
    assign head_vld   = !empty && !head_err;

    // Gated by rst_n so the port reads 0 throughout reset, yet rises as soon as reset releases.
    assign ready_in = rst_n && !full && ((state_q == IDLE) || (state_q == STREAM));
    assign push     = valid_in && ready_in;

    assign valid_out_a = head_vld && (head_route == RT_A);
    assign valid_out_b = head_vld && (head_route == RT_B);
    assign valid_out_c = head_vld && (head_route == RT_C);
    assign data_out_a  = valid_out_a ? head_data : 8'h00;
    assign data_out_b  = valid_out_b ? head_data : 8'h00;
    assign data_out_c  = valid_out_c ? head_data : 8'h00;

    // A bad head never asserts a valid; it leaves at the first edge it sits at the head.
    assign pop = !empty && (head_err
                            || (valid_out_a && ready_a)
                            || (valid_out_b && ready_b)
                            || (valid_out_c && ready_c));

    assign err_count = err_count_q;
    assign busy      = !empty;

    always_comb begin
        route_sel = RT_C;
        if ((mode == 2'b00) && config_bits[0]) begin
            route_sel = RT_A;
        end else if ((mode == 2'b01) && (|config_bits[3:2])) begin
            route_sel = RT_B;
        end
    end

    always_comb begin
        mem_data_d  = mem_data_q;
        mem_route_d = mem_route_q;
        mem_err_d   = mem_err_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        err_count_d = err_count_q;

        if (push) begin
            mem_data_d[wr_ptr_q]  = data_in;
            mem_route_d[wr_ptr_q] = route_sel;
            mem_err_d[wr_ptr_q]   = error_in;
            wr_ptr_d              = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            if (head_err && (err_count_q != 4'hF)) begin
                err_count_d = err_count_q + 4'd1;
            end
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State always mirrors (empty?, halted?) of the post-edge buffer and mode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (mode == MODE_HALT) begin
                    state_d = push ? DRAIN : HALT;
                end else if (push) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (count_d == '0) begin
                    state_d = (mode == MODE_HALT) ? HALT : IDLE;
                end else if (mode == MODE_HALT) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (count_d == '0) begin
                    state_d = (mode == MODE_HALT) ? HALT : IDLE;
                end else if (mode != MODE_HALT) begin
                    state_d = STREAM;
                end
            end
            HALT: begin
                if (mode != MODE_HALT) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            err_count_q <= 4'h0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data_q[i]  <= 8'h00;
                mem_route_q[i] <= RT_C;
                mem_err_q[i]   <= 1'b0;
            end
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            err_count_q <= err_count_d;
            mem_data_q  <= mem_data_d;
            mem_route_q <= mem_route_d;
            mem_err_q   <= mem_err_d;
        end
    end

endmodule

// File: doc/test_cond_router.md
TEST_COND_ROUTER -- requirements
Module: test_cond_router

Interface
REQ-001 Parameter: DEPTH, default 4, buffer entries (power of two, >=2).
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 mode  input  2  routing mode; 2'b11 = halt intake.
REQ-006 config_bits  input  4  routing qualifiers.
REQ-007 data_in  input  8  inbound data beat.
REQ-008 valid_in  input  1  data_in/error_in valid.
REQ-009 error_in  input  1  beat marked bad by upstream.
REQ-010 ready_in  output  1  block can accept a beat.
REQ-011 data_out_a / data_out_b / data_out_c  output  8 each  per-channel data.
REQ-012 valid_out_a / valid_out_b / valid_out_c  output  1 each  per-channel valid.
REQ-013 ready_a / ready_b / ready_c  input  1 each  per-channel downstream ready.
REQ-014 err_count  output  4  count of dropped bad beats.
REQ-015 busy  output  1  buffer non-empty.

Function
REQ-016 A beat SHALL be accepted on a rising edge where valid_in=1 and ready_in=1.
REQ-017 ready_in SHALL be 1 iff the buffer is not full and state is IDLE or STREAM; it SHALL NOT depend on same-cycle pops.
REQ-018 The route SHALL be fixed at acceptance from same-cycle mode/config_bits: A if mode==2'b00 and config_bits[0]; else B if mode==2'b01 and |config_bits[3:2]; else C.
REQ-019 Each entry SHALL store data (8), route (2), error_in (1); FIFO order, no reordering.
REQ-020 The head entry with error=0 SHALL drive only its routed channel: valid_out_x=1, data_out_x=head data; the other channels SHALL output valid=0, data=8'h00.
REQ-021 The head SHALL pop on an edge where its valid_out_x=1 and ready_x=1; valid_out_x SHALL stay high and data stable until popped.
REQ-022 A head entry with error=1 SHALL be popped one cycle after reaching the head with no valid_out asserted, and err_count SHALL increment, saturating at 4'hF.
REQ-023 Latency: an accepted beat SHALL appear on its channel no earlier than the next cycle (registered buffer, no bypass).
REQ-024 Push and pop in the same cycle SHALL both take effect; occupancy is unchanged.
REQ-025 The pointers SHALL wrap modulo DEPTH; full = occupancy DEPTH, empty = 0.
REQ-026 The FSM SHALL have states IDLE, STREAM, DRAIN, and HALT.
REQ-027 IDLE (empty, mode!=11): to STREAM on push; to HALT if mode==11.
REQ-028 STREAM (non-empty, mode!=11): to DRAIN if mode==11; to IDLE when the last entry pops with no push.
REQ-029 DRAIN (non-empty, mode==11): no accepts; output continues; to HALT when empty; to STREAM if mode!=11.
REQ-030 HALT (empty, mode==11): no accepts; to IDLE when mode!=11.
REQ-031 busy SHALL equal occupancy != 0.
REQ-032 Mode/config changes SHALL NOT affect routes of entries already buffered.

Reset
REQ-033 While rst_n=0: state IDLE, buffer empty, pointers 0, ready_in=0, all valid_out_x=0, data_out_x=8'h00, err_count=4'h0, busy=0.
REQ-034 Reset mid-operation SHALL discard all buffered entries immediately (asynchronous).
REQ-035 ready_in SHALL assert in the first cycle after rst_n deasserts.

Verification
REQ-036 mode=00, cfg=4'b0001, data_in=8'h5A valid 1 cycle, ready_a=1 -> next cycle valid_out_a=1, data_out_a=8'h5A; popped; others 0.
REQ-037 mode=01, cfg=4'b0100, push 8'h11, 8'h22, ready_b=0 for 3 cycles, then 1 -> 8'h11 held on B, then 8'h22 the next cycle.
REQ-038 mode=10, push 4 beats with all readies=0 -> ready_in=0 after 4th accept; raise ready_c -> drain in order; ready_in returns 1 the cycle after the first pop.
REQ-039 Push 8'h90 with error_in=1, then 8'h01 to A -> no valid for 8'h90; err_count=1; 8'h01 appears on A next; 16 bad beats -> err_count holds 4'hF.
REQ-040 2 beats buffered, mode->11 -> DRAIN, ready_in=0, both drain, then HALT; mode->00 -> IDLE, ready_in=1.
REQ-041 rst_n pulsed low with 3 entries buffered -> all valid_out_x=0, busy=0, and err_count=0 immediately.
